id_decode_stage: RTL and testbench
==================================

# id_decode_stage

Pipelined RV32I instruction decode stage sitting between fetch and execute. It accepts one instruction per cycle through a valid/ready handshake and decodes it into the control fields the execute-stage ALU consumes: `alu_op`, `sub`, `arith_shift`, `branch_op`, immediate and register indices. Results are presented from a registered output through a 2-entry skid buffer, so neither side sees a combinational ready path.

## Interface
Parameters:
- none; XLEN is fixed at 32.

Ports:
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_instr_valid`  in  1  fetch has an instruction on `i_instr`/`i_pc`.
- `o_instr_ready`  out  1  stage can accept; registered.
- `i_instr`  in  32  raw instruction word.
- `i_pc`  in  32  PC of `i_instr`.
- `i_flush`  in  1  discard all held and incoming instructions.
- `o_valid`  out  1  decoded bundle valid.
- `i_ready`  in  1  execute accepts the bundle.
- `o_pc`  out  32  PC passed through unchanged.
- `o_rd`, `o_rs1`, `o_rs2`  out  5 each  register indices from `instr[11:7]`, `[19:15]`, `[24:20]`.
- `o_imm`  out  32  sign-extended immediate.
- `o_use_imm`  out  1  ALU operand b is `o_imm`, not rs2.
- `o_alu_op`  out  3  ALU operation select.
- `o_sub`  out  1  subtract when `alu_op` is 000.
- `o_arith_shift`  out  1  arithmetic right shift when `alu_op` is 101.
- `o_branch_op`  out  3  branch comparison select.
- `o_is_jal`, `o_is_jalr`, `o_is_load`, `o_is_store`, `o_is_lui`, `o_is_auipc`  out  1 each  instruction class flags.
- `o_reg_write`  out  1  writes rd.
- `o_illegal`  out  1  unsupported or malformed encoding.

## Operation
- Opcode `instr[6:0]` selects the class:
  - 0110011 OP
  - 0010011 OP-IMM
  - 0000011 LOAD
  - 0100011 STORE
  - 1100011 BRANCH
  - 1101111 JAL
  - 1100111 JALR
  - 0110111 LUI
  - 0010111 AUIPC
  - any other opcode is illegal.
- Immediate formats (all sign-extended from `instr[31]`):
  - I: OP-IMM, LOAD, JALR
  - S: STORE
  - B: BRANCH, bit 0 = 0
  - U: LUI, AUIPC, low 12 bits = 0
  - J: JAL, bit 0 = 0
  - OP: `o_imm` = 0.
- `o_alu_op`: `funct3` for OP and OP-IMM; 000 for all other classes (address/add).
- `o_sub`: `instr[30]` for OP with `funct3` = 000; otherwise 0. ADDI never subtracts.
- `o_arith_shift`: `instr[30]` for OP or OP-IMM with `funct3` = 101; otherwise 0.
- `o_branch_op`: `funct3` for BRANCH; otherwise 010, which the ALU evaluates as never-branch.
- `o_use_imm` = 0 for OP and BRANCH, 1 for all other classes.
- `o_reg_write` = 1 for OP, OP-IMM, LOAD, JAL, JALR, LUI, AUIPC, and only when the instruction is not illegal.
- Illegal conditions:
  - unknown opcode;
  - BRANCH with `funct3` 010 or 011;
  - OP with `funct7` not 0000000/0100000;
  - OP with `funct7` 0100000 and `funct3` not 000 or 101;
  - OP-IMM `funct3` 001 with `funct7` not 0;
  - OP-IMM `funct3` 101 with `funct7` not 0000000/0100000;
  - JALR with `funct3` not 0.
- An illegal instruction is still delivered, with `o_illegal` = 1. All other fields follow the rules above.
- Buffering: output register (OUT) plus one skid register (SKID). `o_instr_ready` = !SKID.valid.
  - Accept occurs when `i_instr_valid` and `o_instr_ready` are both 1.
  - Decode is combinational on `i_instr` and is captured at accept.
  - If OUT is empty or drains this cycle, the accepted bundle goes to OUT; otherwise it goes to SKID.
  - When OUT drains (`o_valid` and `i_ready` both 1) and SKID is valid, SKID moves to OUT.
  - Order is strictly preserved; no bundle is dropped or duplicated.

## Timing
- Latency: an instruction accepted at edge N is visible on `o_valid`/payload after edge N, i.e. in the cycle following the accept.
- Throughput: 1 instruction per cycle while `i_ready` = 1.
- `o_instr_ready` deasserts the cycle after SKID fills. It reasserts the cycle after SKID empties.
- While `o_valid` = 1 and `i_ready` = 0, the payload is held stable.
- `i_flush` (synchronous, takes priority over everything):
  - the next cycle has `o_valid` = 0 and `o_instr_ready` = 1;
  - an instruction accepted in the flush cycle is discarded;
  - a simultaneous downstream handshake in the flush cycle still completes.
- Reset (asynchronous, active-high, effective immediately, including mid-stream):
  - `o_valid` = 0 and SKID is invalid;
  - `o_instr_ready` = 1;
  - all payload outputs = 0, except `o_branch_op` = 010.
  - The first accept can occur on the first edge after `i_rst` falls.

## Test plan
- ADD x3,x1,x2 (0x002081B3) → `o_alu_op` 000, `o_sub` 0, rd 3, rs1 1, rs2 2, `o_use_imm` 0, `o_reg_write` 1, `o_branch_op` 010. SUB (0x402081B3) → `o_sub` 1.
- SRAI x5,x6,3 (0x40335293) → `o_alu_op` 101, `o_arith_shift` 1, `o_imm` 0x00000403, `o_use_imm` 1. SRLI (0x00335293) → `o_arith_shift` 0.
- BLT x1,x2,-8 (0xFE20CCE3) → `o_branch_op` 100, `o_imm` 0xFFFFFFF8, `o_use_imm` 0, `o_reg_write` 0. LUI x1,0x12345 (0x123450B7) → `o_imm` 0x12345000, `o_is_lui` 1.
- Backpressure: `i_ready` = 0, offer 3 back-to-back instructions → exactly 2 accepted and `o_instr_ready` = 0. Then `i_ready` = 1 → all 3 delivered in order on consecutive cycles, no duplicates.
- Flush with OUT and SKID full plus an instruction offered → next cycle `o_valid` = 0, `o_instr_ready` = 1, and none of the 3 instructions is ever delivered.
- 0x00000000 → `o_illegal` 1, `o_reg_write` 0. Assert `i_rst` mid-stream → outputs take reset values immediately, and the stream resumes cleanly after release.

Source files
------------

// File: rtl/id_decode_stage.sv
`default_nettype none
// ============================================================================
// id_decode_stage : RV32I decode stage with registered output and 2-entry skid
// Revision 1.0
// ============================================================================
module id_decode_stage (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_instr_valid,
  output logic        o_instr_ready,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  input  logic        i_flush,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_pc,
  output logic [4:0]  o_rd,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [31:0] o_imm,
  output logic        o_use_imm,
  output logic [2:0]  o_alu_op,
  output logic        o_sub,
  output logic        o_arith_shift,
  output logic [2:0]  o_branch_op,
  output logic        o_is_jal,
  output logic        o_is_jalr,
  output logic        o_is_load,
  output logic        o_is_store,
  output logic        o_is_lui,
  output logic        o_is_auipc,
  output logic        o_reg_write,
  output logic        o_illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [2:0] BR_NEVER   = 3'b010;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        use_imm;
    logic [2:0]  alu_op;
    logic        sub;
    logic        arith_shift;
    logic [2:0]  branch_op;
    logic        is_jal;
    logic        is_jalr;
    logic        is_load;
    logic        is_store;
    logic        is_lui;
    logic        is_auipc;
    logic        reg_write;
    logic        illegal;
  } bundle_t;

  localparam bundle_t RESET_BUNDLE = '{branch_op: BR_NEVER, default: '0};

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        writes_rd;
  bundle_t     dec;

  assign opcode = i_instr[6:0];
  assign funct3 = i_instr[14:12];
  assign funct7 = i_instr[31:25];

  assign imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
  assign imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                  i_instr[11:8], 1'b0};
  assign imm_u = {i_instr[31:12], 12'b0};
  assign imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                  i_instr[30:21], 1'b0};

  always_comb begin
    dec           = RESET_BUNDLE;
    writes_rd     = 1'b0;
    dec.pc        = i_pc;
    dec.rd        = i_instr[11:7];
    dec.rs1       = i_instr[19:15];
    dec.rs2       = i_instr[24:20];
    dec.use_imm   = 1'b1;
    case (opcode)
      OPC_OP: begin
        dec.use_imm     = 1'b0;
        dec.alu_op      = funct3;
        dec.sub         = (funct3 == 3'b000) && i_instr[30];
        dec.arith_shift = (funct3 == 3'b101) && i_instr[30];
        dec.illegal     = !((funct7 == F7_ZERO) ||
                            ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
        writes_rd       = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.imm         = imm_i;
        dec.alu_op      = funct3;
        dec.arith_shift = (funct3 == 3'b101) && i_instr[30];
        // shift-immediate encodings reuse the upper imm bits as funct7
        dec.illegal     = ((funct3 == 3'b001) && (funct7 != F7_ZERO)) ||
                          ((funct3 == 3'b101) && (funct7 != F7_ZERO) && (funct7 != F7_ALT));
        writes_rd       = 1'b1;
      end
      OPC_LOAD: begin
        dec.imm     = imm_i;
        dec.is_load = 1'b1;
        writes_rd   = 1'b1;
      end
      OPC_STORE: begin
        dec.imm      = imm_s;
        dec.is_store = 1'b1;
      end
      OPC_BRANCH: begin
        dec.imm       = imm_b;
        dec.use_imm   = 1'b0;
        dec.branch_op = funct3;
        dec.illegal   = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OPC_JAL: begin
        dec.imm    = imm_j;
        dec.is_jal = 1'b1;
        writes_rd  = 1'b1;
      end
      OPC_JALR: begin
        dec.imm     = imm_i;
        dec.is_jalr = 1'b1;
        dec.illegal = (funct3 != 3'b000);
        writes_rd   = 1'b1;
      end
      OPC_LUI: begin
        dec.imm    = imm_u;
        dec.is_lui = 1'b1;
        writes_rd  = 1'b1;
      end
      OPC_AUIPC: begin
        dec.imm      = imm_u;
        dec.is_auipc = 1'b1;
        writes_rd    = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.reg_write = writes_rd && !dec.illegal;
  end

  bundle_t out_q, skid_q;
  logic    out_valid, skid_valid;
  logic    accept, drain;

  assign o_instr_ready = !skid_valid;
  assign accept        = i_instr_valid && o_instr_ready;
  assign drain         = out_valid && i_ready;

  // SKID only fills while OUT is stalled, so OUT is never empty with SKID valid
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      out_q      <= RESET_BUNDLE;
      skid_q     <= RESET_BUNDLE;
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (i_flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || drain) begin
      if (skid_valid) begin
        out_q      <= skid_q;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_q      <= dec;
        out_valid  <= 1'b1;
      end else begin
        out_valid  <= 1'b0;
      end
    end else if (accept) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
    end
  end

  assign o_valid       = out_valid;
  assign o_pc          = out_q.pc;
  assign o_rd          = out_q.rd;
  assign o_rs1         = out_q.rs1;
  assign o_rs2         = out_q.rs2;
  assign o_imm         = out_q.imm;
  assign o_use_imm     = out_q.use_imm;
  assign o_alu_op      = out_q.alu_op;
  assign o_sub         = out_q.sub;
  assign o_arith_shift = out_q.arith_shift;
  assign o_branch_op   = out_q.branch_op;
  assign o_is_jal      = out_q.is_jal;
  assign o_is_jalr     = out_q.is_jalr;
  assign o_is_load     = out_q.is_load;
  assign o_is_store    = out_q.is_store;
  assign o_is_lui      = out_q.is_lui;
  assign o_is_auipc    = out_q.is_auipc;
  assign o_reg_write   = out_q.reg_write;
  assign o_illegal     = out_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_id_decode_stage.sv
`default_nettype none
// ============================================================================
// tb_id_decode_stage : directed scoreboard bench for id_decode_stage
// Revision 1.0
// ============================================================================
module tb_id_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        use_imm;
    logic [2:0]  alu_op;
    logic        sub;
    logic        ash;
    logic [2:0]  bop;
    logic        jal;
    logic        jalr;
    logic        load;
    logic        store;
    logic        lui;
    logic        auipc;
    logic        rw;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_instr_valid, i_flush, i_ready;
  logic [31:0] i_instr, i_pc;
  logic        o_instr_ready, o_valid;
  logic [31:0] o_pc, o_imm;
  logic [4:0]  o_rd, o_rs1, o_rs2;
  logic        o_use_imm, o_sub, o_arith_shift;
  logic [2:0]  o_alu_op, o_branch_op;
  logic        o_is_jal, o_is_jalr, o_is_load, o_is_store, o_is_lui, o_is_auipc;
  logic        o_reg_write, o_illegal;

  int compared   = 0;
  int mismatched = 0;
  int delivered  = 0;
  int cur_idx    = 0;
  exp_t sb[$];

  logic [31:0] instr_tab [9] = '{
    32'h002081B3,  // ADD  x3,x1,x2
    32'h402081B3,  // SUB  x3,x1,x2
    32'h40335293,  // SRAI x5,x6,3
    32'h00335293,  // SRLI x5,x6,3
    32'hFE20CCE3,  // BLT  x1,x2,-8
    32'h123450B7,  // LUI  x1,0x12345
    32'h00000000,  // illegal
    32'h0020A423,  // SW   x2,8(x1)
    32'h010000EF   // JAL  x1,+16
  };

  always #5 clk = ~clk;

  id_decode_stage dut (
    .i_clk(clk), .i_rst(rst), .i_instr_valid(i_instr_valid), .o_instr_ready(o_instr_ready),
    .i_instr(i_instr), .i_pc(i_pc), .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
    .o_pc(o_pc), .o_rd(o_rd), .o_rs1(o_rs1), .o_rs2(o_rs2), .o_imm(o_imm),
    .o_use_imm(o_use_imm), .o_alu_op(o_alu_op), .o_sub(o_sub), .o_arith_shift(o_arith_shift),
    .o_branch_op(o_branch_op), .o_is_jal(o_is_jal), .o_is_jalr(o_is_jalr),
    .o_is_load(o_is_load), .o_is_store(o_is_store), .o_is_lui(o_is_lui),
    .o_is_auipc(o_is_auipc), .o_reg_write(o_reg_write), .o_illegal(o_illegal)
  );

  function automatic exp_t mk(logic [31:0] pc, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                              logic [31:0] imm, logic use_imm, logic [2:0] alu, logic sub,
                              logic ash, logic [2:0] bop, logic [5:0] flags, logic rw, logic ill);
    exp_t e;
    e.pc = pc; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm; e.use_imm = use_imm;
    e.alu_op = alu; e.sub = sub; e.ash = ash; e.bop = bop;
    {e.jal, e.jalr, e.load, e.store, e.lui, e.auipc} = flags;
    e.rw = rw; e.ill = ill;
    return e;
  endfunction

  // Hand-decoded expectations; flags order is {jal,jalr,load,store,lui,auipc}
  function automatic exp_t exp_of(int idx, logic [31:0] pc);
    case (idx)
      0: return mk(pc, 5'd3,  5'd1, 5'd2,  32'h0,        1'b0, 3'b000, 1'b0, 1'b0, 3'b010, 6'b000000, 1'b1, 1'b0);
      1: return mk(pc, 5'd3,  5'd1, 5'd2,  32'h0,        1'b0, 3'b000, 1'b1, 1'b0, 3'b010, 6'b000000, 1'b1, 1'b0);
      2: return mk(pc, 5'd5,  5'd6, 5'd3,  32'h00000403, 1'b1, 3'b101, 1'b0, 1'b1, 3'b010, 6'b000000, 1'b1, 1'b0);
      3: return mk(pc, 5'd5,  5'd6, 5'd3,  32'h00000003, 1'b1, 3'b101, 1'b0, 1'b0, 3'b010, 6'b000000, 1'b1, 1'b0);
      4: return mk(pc, 5'd25, 5'd1, 5'd2,  32'hFFFFFFF8, 1'b0, 3'b000, 1'b0, 1'b0, 3'b100, 6'b000000, 1'b0, 1'b0);
      5: return mk(pc, 5'd1,  5'd8, 5'd3,  32'h12345000, 1'b1, 3'b000, 1'b0, 1'b0, 3'b010, 6'b000010, 1'b1, 1'b0);
      6: return mk(pc, 5'd0,  5'd0, 5'd0,  32'h0,        1'b0, 3'b000, 1'b0, 1'b0, 3'b010, 6'b000000, 1'b0, 1'b1);
      7: return mk(pc, 5'd8,  5'd1, 5'd2,  32'h00000008, 1'b1, 3'b000, 1'b0, 1'b0, 3'b010, 6'b000100, 1'b0, 1'b0);
      default: return mk(pc, 5'd1, 5'd0, 5'd16, 32'h00000010, 1'b1, 3'b000, 1'b0, 1'b0, 3'b010, 6'b100000, 1'b1, 1'b0);
    endcase
  endfunction

  // The immediate and operand-b select of an unknown opcode are left unconstrained
  function automatic exp_t mask_of(int idx);
    exp_t m = '1;
    if (idx == 6) begin
      m.imm = '0;
      m.use_imm = 1'b0;
    end
    return m;
  endfunction

  function automatic exp_t get_obs();
    exp_t o;
    o.pc = o_pc; o.rd = o_rd; o.rs1 = o_rs1; o.rs2 = o_rs2; o.imm = o_imm;
    o.use_imm = o_use_imm; o.alu_op = o_alu_op; o.sub = o_sub; o.ash = o_arith_shift;
    o.bop = o_branch_op; o.jal = o_is_jal; o.jalr = o_is_jalr; o.load = o_is_load;
    o.store = o_is_store; o.lui = o_is_lui; o.auipc = o_is_auipc;
    o.rw = o_reg_write; o.ill = o_illegal;
    return o;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: push on accept, pop on downstream handshake, check hold stability
  exp_t   sb_mask[$];
  exp_t   prev_obs;
  logic   hold_prev = 1'b0;
  always @(negedge clk) begin
    exp_t obs, e, m;
    if (rst) begin
      sb.delete();
      sb_mask.delete();
      hold_prev = 1'b0;
    end else begin
      obs = get_obs();
      if (hold_prev && o_valid)
        chk("hold_stable", obs, prev_obs);
      if (o_valid && i_ready) begin
        compared++;
        assert (sb.size() != 0) else begin
          mismatched++;
          $error("FAIL unexpected_delivery: observed pc %h expected none", o_pc);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          m = sb_mask.pop_front();
          chk("deliver", obs & m, e & m);
          delivered++;
        end
      end
      hold_prev = o_valid && !i_ready && !i_flush;
      prev_obs  = obs;
      if (i_flush) begin
        sb.delete();
        sb_mask.delete();
      end else if (i_instr_valid && o_instr_ready) begin
        sb.push_back(exp_of(cur_idx, i_pc));
        sb_mask.push_back(mask_of(cur_idx));
      end
    end
  end

  task automatic drive(input int idx, input logic [31:0] pc);
    cur_idx       = idx;
    i_instr       = instr_tab[idx];
    i_pc          = pc;
    i_instr_valid = 1'b1;
  endtask

  task automatic offer(input int idx, input logic [31:0] pc);
    logic acc;
    int   n = 0;
    drive(idx, pc);
    forever begin
      @(negedge clk);
      acc = o_instr_ready;
      @(posedge clk); #1;
      if (acc) break;
      n++;
      if (n > 50) begin
        chk("offer_timeout", 1, 0);
        break;
      end
    end
    i_instr_valid = 1'b0;
  endtask

  task automatic drain_wait();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  exp_t rst_val;
  int   acc_cnt, d0;

  initial begin
    rst_val = mk(32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 3'b000, 1'b0, 1'b0, 3'b010, 6'b0, 1'b0, 1'b0);
    rst = 1'b1; i_instr_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
    i_instr = '0; i_pc = '0;
    #1;
    chk("reset_valid", o_valid, 0);
    chk("reset_ready", o_instr_ready, 1);
    chk("reset_payload", get_obs(), rst_val);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Back-to-back stream of every decode pattern
    for (int i = 0; i < 9; i++) offer(i, 32'h1000 + 32'(4 * i));
    drain_wait();
    chk("stream_count", delivered, 9);

    // Backpressure: three offered, two accepted, then released
    i_ready = 1'b0;
    acc_cnt = 0;
    d0 = delivered;
    for (int k = 0; k < 3; k++) begin
      drive((k == 0) ? 0 : (k == 1) ? 4 : 5, 32'h2000 + 32'(4 * k));
      @(negedge clk);
      if (o_instr_ready) acc_cnt++;
      @(posedge clk); #1;
    end
    chk("bp_accepted", acc_cnt, 2);
    chk("bp_ready_low", o_instr_ready, 0);
    i_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_consecutive", o_valid, 1);
      @(posedge clk); #1;
      if (k == 1) i_instr_valid = 1'b0;
    end
    @(negedge clk);
    chk("bp_idle", o_valid, 0);
    chk("bp_count", delivered, d0 + 3);

    // Flush with OUT and SKID full and a third instruction offered
    @(posedge clk); #1;
    i_ready = 1'b0;
    d0 = delivered;
    drive(1, 32'h3000); @(posedge clk); #1;
    drive(2, 32'h3004); @(posedge clk); #1;
    drive(3, 32'h3008); i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0; i_instr_valid = 1'b0;
    chk("flush_valid", o_valid, 0);
    chk("flush_ready", o_instr_ready, 1);
    i_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("flush_nothing", delivered, d0);

    // Instruction accepted in a flush cycle is discarded
    drive(5, 32'h3100); i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0; i_instr_valid = 1'b0;
    chk("flush_accept_valid", o_valid, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("flush_accept_none", delivered, d0);

    // Asynchronous reset mid-stream, then resume
    i_ready = 1'b0;
    drive(5, 32'h4000); @(posedge clk); #1;
    drive(7, 32'h4004); @(posedge clk); #1;
    i_instr_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", o_valid, 0);
    chk("midrst_ready", o_instr_ready, 1);
    chk("midrst_payload", get_obs(), rst_val);
    @(posedge clk); #1 rst = 1'b0;
    i_ready = 1'b1;
    d0 = delivered;
    offer(2, 32'h5000);
    offer(8, 32'h5004);
    offer(6, 32'h5008);
    drain_wait();
    chk("resume_count", delivered, d0 + 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
